tile_display_driver: RTL and testbench

- Parametrised VGA tile-grid display driver. It generates its own sync timing and walks a GRID_W x GRID_H framebuffer of 1-byte cells in CPU memory.
- Maps each cell to a programmable 16-entry 12-bit palette and outputs registered RGB444 with matched hsync/vsync.
- Sits between the memory read port (video side) and the VGA DAC pins. The pixel clock is supplied either as clk directly or via pix_en from a faster clk.

---
 rtl/tile_display_pkg.sv | 37 +++
 rtl/tile_display_driver_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 63 ++++++
 rtl/tile_display_driver.sv | 205 ++++++++++++++++++++
 tb/tb_tile_display_driver.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_display_pkg.sv
// Shared types and defaults for the tile-grid VGA display driver and its timing generator.
package tile_display_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel side information carried down the output delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic grid;
    logic border;
    logic fs;
  } pix_flags_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Entry 15 is the leftmost element, entry 0 the rightmost.
  localparam logic [15:0][11:0] DEFAULT_PALETTE = {
    12'h444, 12'h808, 12'h088, 12'h880,
    12'h008, 12'h080, 12'h800, 12'h888,
    12'hf0f, 12'h0ff, 12'hff0, 12'h00f,
    12'h0f0, 12'hf00, 12'hfff, 12'h000
  };

endpackage

// File: rtl/tile_display_driver_if.sv
// Video-side bundle of the tile display driver: memory read port, palette write port, DAC pins.
interface tile_display_driver_if;

  logic        pix_en;
  logic [15:0] color_address;
  logic [7:0]  color_data;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_rgb;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        video_active;
  logic        frame_start;

  modport master (
    input  pix_en, color_data, pal_we, pal_idx, pal_rgb,
    output color_address, red, green, blue, hsync, vsync, video_active, frame_start
  );

  modport slave (
    output pix_en, color_data, pal_we, pal_idx, pal_rgb,
    input  color_address, red, green, blue, hsync, vsync, video_active, frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Generic VGA h/v counters with raw (active-high) sync, visible-area flag and wrap strobes.
module vga_timing_gen
  import tile_display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned H_BITS   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
  parameter int unsigned V_BITS   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [H_BITS-1:0] h,
  output logic [V_BITS-1:0] v,
  output logic              hsync_raw,
  output logic              vsync_raw,
  output logic              active,
  output logic              line_end,
  output logic              frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_BITS-1:0] H_LAST   = H_BITS'(H_TOTAL - 1);
  localparam logic [H_BITS-1:0] H_VIS    = H_BITS'(H_ACTIVE);
  localparam logic [H_BITS-1:0] HS_START = H_BITS'(H_ACTIVE + H_FP);
  localparam logic [H_BITS-1:0] HS_END   = H_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_BITS-1:0] V_LAST   = V_BITS'(V_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_VIS    = V_BITS'(V_ACTIVE);
  localparam logic [V_BITS-1:0] VS_START = V_BITS'(V_ACTIVE + V_FP);
  localparam logic [V_BITS-1:0] VS_END   = V_BITS'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (en) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) v <= '0;
        else             v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_comb begin
    line_end  = (h == H_LAST);
    frame_end = (h == H_LAST) && (v == V_LAST);
    hsync_raw = (h >= HS_START) && (h < HS_END);
    vsync_raw = (v >= VS_START) && (v < VS_END);
    active    = (h < H_VIS) && (v < V_VIS);
  end

endmodule

// File: rtl/tile_display_driver.sv
// VGA tile-grid driver: walks a GRID_W x GRID_H byte framebuffer, maps cells through a
// 16-entry palette and drives registered RGB444 with syncs delayed to match the pixel pipeline.
module tile_display_driver
  import tile_display_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned GRID_W      = 32,
  parameter int unsigned GRID_H      = 32,
  parameter int unsigned CELL        = 15,
  parameter int unsigned X_OFFSET    = 80,
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          BORDER_EN   = 1'b1,
  parameter logic [11:0] BORDER_RGB  = 12'hfff
) (
  input logic                  clk,
  input logic                  reset,
  tile_display_driver_if.master bus
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_BITS     = $clog2(H_TOTAL + 1);
  localparam int unsigned V_BITS     = $clog2(V_TOTAL + 1);
  localparam int unsigned L          = MEM_LATENCY + 2;
  localparam int unsigned GRID_PIX_W = GRID_W * CELL;
  localparam int unsigned GRID_PIX_H = GRID_H * CELL;
  localparam int unsigned SUB_BITS   = $clog2(CELL + 1);
  localparam int unsigned COL_BITS   = $clog2(GRID_W + 1);
  localparam int unsigned ROW_BITS   = $clog2(GRID_H + 1);

  localparam logic [H_BITS-1:0]   X_FIRST  = H_BITS'(X_OFFSET);
  localparam logic [H_BITS-1:0]   X_LAST   = H_BITS'(X_OFFSET + GRID_PIX_W - 1);
  localparam logic [H_BITS-1:0]   X_CLEAR  = H_BITS'((X_OFFSET == 0) ? (H_TOTAL - 1) : (X_OFFSET - 1));
  localparam logic [V_BITS-1:0]   Y_LAST   = V_BITS'(GRID_PIX_H - 1);
  localparam logic [SUB_BITS-1:0] SUB_LAST = SUB_BITS'(CELL - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(GRID_W - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(GRID_H - 1);
  localparam logic [15:0]         ROW_STEP = 16'(GRID_W);

  localparam pix_flags_t FLAGS_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, default: 1'b0};

  if (GRID_PIX_W + X_OFFSET > H_ACTIVE || GRID_PIX_H > V_ACTIVE) begin : g_geometry_check
    $error("tile_display_driver: tile grid does not fit inside the active area");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_latency_check
    $error("tile_display_driver: MEM_LATENCY must be within 1..4");
  end

  logic [H_BITS-1:0] h;
  logic [V_BITS-1:0] v;
  logic              hsync_raw;
  logic              vsync_raw;
  logic              active;
  logic              line_end;
  logic              frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_BITS   (H_BITS),
    .V_BITS   (V_BITS)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.pix_en),
    .h         (h),
    .v         (v),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active    (active),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  logic [SUB_BITS-1:0] sub_x;
  logic [SUB_BITS-1:0] sub_y;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [15:0]         row_base;
  logic                in_x;
  logic                in_y;
  pix_flags_t          cur;

  always_comb begin
    in_x       = (h >= X_FIRST) && (h <= X_LAST);
    in_y       = (v <= Y_LAST);
    cur        = FLAGS_IDLE;
    cur.hs     = hsync_raw ? SYNC_POL : ~SYNC_POL;
    cur.vs     = vsync_raw ? SYNC_POL : ~SYNC_POL;
    cur.act    = active;
    cur.grid   = in_x && in_y;
    cur.border = BORDER_EN && in_x && in_y &&
                 ((h == X_FIRST) || (h == X_LAST) || (v == '0) || (v == Y_LAST));
    cur.fs     = (h == '0) && (v == '0);
  end

  // Cell coordinates are tracked incrementally so that col/row always describe the
  // current h/v; the counters stop at the last cell instead of overflowing past the grid.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_x    <= '0;
      col      <= '0;
      sub_y    <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (bus.pix_en) begin
      if (h == X_CLEAR) begin
        sub_x <= '0;
        col   <= '0;
      end else if (in_x) begin
        if (sub_x == SUB_LAST) begin
          sub_x <= '0;
          if (col != COL_LAST) col <= col + 1'b1;
        end else begin
          sub_x <= sub_x + 1'b1;
        end
      end
      if (frame_end) begin
        sub_y    <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (line_end && in_y) begin
        if (sub_y == SUB_LAST) begin
          sub_y <= '0;
          if (row != ROW_LAST) begin
            row      <= row + 1'b1;
            row_base <= row_base + ROW_STEP;
          end
        end else begin
          sub_y <= sub_y + 1'b1;
        end
      end
    end
  end

  logic [15:0] addr_q;

  always_ff @(posedge clk) begin
    if (reset)                            addr_q <= BASE_ADDR;
    else if (bus.pix_en && in_x && in_y)  addr_q <= BASE_ADDR + row_base + 16'(col);
  end

  rgb444_t pal [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) pal[i] <= rgb444_t'(DEFAULT_PALETTE[i]);
    end else if (bus.pal_we) begin
      pal[bus.pal_idx] <= rgb444_t'(bus.pal_rgb);
    end
  end

  pix_flags_t dly [L];
  rgb444_t    pix_rgb;
  rgb444_t    rgb_q;
  logic       frame_q;

  // dly[L-2] describes the pixel whose memory byte is on color_data this cycle,
  // so the colour chosen here lands on the pins together with dly[L-1].
  always_comb begin
    pix_rgb = pal[bus.color_data[3:0]];
    if (dly[L-2].border)                       pix_rgb = rgb444_t'(BORDER_RGB);
    else if (!dly[L-2].act || !dly[L-2].grid)  pix_rgb = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < L; i++) dly[i] <= FLAGS_IDLE;
      rgb_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= bus.pix_en && dly[L-2].fs;
      if (bus.pix_en) begin
        dly[0] <= cur;
        for (int unsigned i = 1; i < L; i++) dly[i] <= dly[i-1];
        rgb_q <= pix_rgb;
      end
    end
  end

  assign bus.color_address = addr_q;
  assign bus.red           = rgb_q.r;
  assign bus.green         = rgb_q.g;
  assign bus.blue          = rgb_q.b;
  assign bus.hsync         = dly[L-1].hs;
  assign bus.vsync         = dly[L-1].vs;
  assign bus.video_active  = dly[L-1].act;
  assign bus.frame_start   = frame_q;

endmodule

// File: tb/tb_tile_display_driver.sv
// Directed bench for tile_display_driver on a shrunk 24x17 raster with a 3x2 grid of 4-pixel cells.
module tb_tile_display_driver;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 3, HT = 24;
  localparam int VA = 12, VFP = 1, VS = 2, VB = 2, VT = 17;
  localparam int FRAME = HT * VT;
  localparam int GW = 3, GH = 2, CELL = 4, XO = 2, ML = 3, L = ML + 2;
  localparam logic [15:0] BASE = 16'h0200;

  localparam logic [11:0] PAL_DEF [16] = '{
    12'h000, 12'hfff, 12'hf00, 12'h0f0, 12'h00f, 12'hff0, 12'h0ff, 12'hf0f,
    12'h888, 12'h800, 12'h080, 12'h008, 12'h880, 12'h088, 12'h808, 12'h444
  };

  localparam int          ADDR_N [9] = '{2, 3, 6, 7, 14, 15, 25, 99, 182};
  localparam logic [15:0] ADDR_V [9] = '{16'h0200, 16'h0200, 16'h0200, 16'h0201, 16'h0202,
                                         16'h0202, 16'h0202, 16'h0203, 16'h0205};
  localparam int          RGB_N  [10] = '{31, 32, 35, 42, 43, 49, 106, 159, 178, 202};
  localparam logic [11:0] RGB_V  [10] = '{12'hfff, 12'hf00, 12'h0f0, 12'hfff, 12'h000,
                                         12'h000, 12'hff0, 12'hf0f, 12'hfff, 12'h000};
  localparam bit          ACT_V  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  tile_display_driver_if bus ();

  tile_display_driver #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .GRID_W (GW), .GRID_H (GH), .CELL (CELL), .X_OFFSET (XO),
    .BASE_ADDR (BASE), .MEM_LATENCY (ML), .BORDER_EN (1'b1), .BORDER_RGB (12'hfff)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with ML pix_en cycles of read latency; cell byte = low address byte + 0x12.
  logic [15:0] mem_pipe [ML];
  always @(posedge clk) begin
    if (bus.pix_en) begin
      mem_pipe[0] <= bus.color_address;
      for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
  end
  assign bus.color_data = mem_byte(mem_pipe[ML-1]);

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] + 8'h12;
  endfunction

  function automatic bit in_grid_px(input int x, input int y);
    return (x >= XO) && (x < XO + GW * CELL) && (y < GH * CELL);
  endfunction

  function automatic logic [15:0] cell_addr(input int x, input int y);
    return BASE + 16'((y / CELL) * GW + (x - XO) / CELL);
  endfunction

  function automatic logic [15:0] exp_addr(input int n);
    for (int m = n - 1; m >= 0; m--) begin
      int p;
      p = m % FRAME;
      if (in_grid_px(p % HT, p / HT)) return cell_addr(p % HT, p / HT);
    end
    return BASE;
  endfunction

  // {color_address, rgb, hsync, vsync, video_active, frame_start} after n enabled cycles.
  function automatic logic [31:0] exp_vec(input int n);
    int p, x, y;
    bit hs, vs, act, fs, grid, brd;
    logic [11:0] rgb;
    logic [7:0] b;
    if (n < L) return {exp_addr(n), 12'h000, 4'b1100};
    p = (n - L) % FRAME;
    x = p % HT;
    y = p / HT;
    hs   = !((x >= HA + HFP) && (x < HA + HFP + HS));
    vs   = !((y >= VA + VFP) && (y < VA + VFP + VS));
    act  = (x < HA) && (y < VA);
    fs   = (p == 0);
    grid = in_grid_px(x, y);
    brd  = grid && (x == XO || x == XO + GW * CELL - 1 || y == 0 || y == GH * CELL - 1);
    b    = mem_byte(cell_addr(x, y));
    if (brd)                rgb = 12'hfff;
    else if (!act || !grid) rgb = 12'h000;
    else                    rgb = PAL_DEF[b[3:0]];
    return {exp_addr(n), rgb, hs, vs, act, fs};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {bus.color_address, bus.red, bus.green, bus.blue,
            bus.hsync, bus.vsync, bus.video_active, bus.frame_start};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.pix_en && !reset) cyc++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.pix_en  = 1'b1;
    bus.pal_we  = 1'b0;
    bus.pal_idx = 4'h0;
    bus.pal_rgb = 12'h000;
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_to(input int target);
    bus.pix_en = 1'b1;
    while (cyc < target) step();
  endtask

  task automatic test_reset();
    logic [31:0] got;
    do_reset();
    got = obs_vec();
    n_checks++;
    if (got !== {16'h0200, 12'h000, 4'b1100}) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", got, {16'h0200, 12'h000, 4'b1100});
    end
  endtask

  task automatic test_frame_scan();
    logic [31:0] got, exp;
    int fs_count;
    fs_count = 0;
    do_reset();
    for (int n = 1; n <= 2 * FRAME + L; n++) begin
      step();
      got = obs_vec();
      exp = exp_vec(cyc);
      if (bus.frame_start) fs_count++;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL frame_scan n=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    n_checks++;
    if (fs_count !== 3) begin
      n_fail++;
      $display("FAIL frame_start_count got=%0d exp=3", fs_count);
    end
  endtask

  task automatic test_address_walk();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_to(ADDR_N[i]);
      n_checks++;
      if (bus.color_address !== ADDR_V[i]) begin
        n_fail++;
        $display("FAIL addr_walk n=%0d got=%h exp=%h", cyc, bus.color_address, ADDR_V[i]);
      end
    end
  endtask

  task automatic test_latency_colour();
    logic [11:0] rgb;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_to(RGB_N[i]);
      rgb = {bus.red, bus.green, bus.blue};
      n_checks++;
      if (rgb !== RGB_V[i] || bus.video_active !== ACT_V[i]) begin
        n_fail++;
        $display("FAIL pixel_colour n=%0d got=%h/%b exp=%h/%b", cyc, rgb, bus.video_active,
                 RGB_V[i], ACT_V[i]);
      end
      if (RGB_N[i] == 49) begin
        n_checks++;
        if (bus.hsync !== 1'b0) begin
          n_fail++;
          $display("FAIL hsync_in_pulse n=%0d got=%b exp=0", cyc, bus.hsync);
        end
      end
    end
  endtask

  task automatic test_palette();
    logic [11:0] rgb;
    do_reset();
    run_to(32);
    bus.pal_we  = 1'b1;
    bus.pal_idx = 4'h2;
    bus.pal_rgb = 12'h0a5;
    step();
    bus.pal_we = 1'b0;
    rgb = {bus.red, bus.green, bus.blue};
    n_checks++;
    if (rgb !== 12'hf00) begin
      n_fail++;
      $display("FAIL pal_same_cycle_old got=%h exp=f00", rgb);
    end
    step();
    rgb = {bus.red, bus.green, bus.blue};
    n_checks++;
    if (rgb !== 12'h0a5) begin
      n_fail++;
      $display("FAIL pal_after_write got=%h exp=0a5", rgb);
    end
    run_to(35);
    rgb = {bus.red, bus.green, bus.blue};
    n_checks++;
    if (rgb !== 12'h0f0) begin
      n_fail++;
      $display("FAIL pal_other_entry got=%h exp=0f0", rgb);
    end
    run_to(56);
    rgb = {bus.red, bus.green, bus.blue};
    n_checks++;
    if (rgb !== 12'h0a5) begin
      n_fail++;
      $display("FAIL pal_next_line got=%h exp=0a5", rgb);
    end
    do_reset();
    run_to(32);
    rgb = {bus.red, bus.green, bus.blue};
    n_checks++;
    if (rgb !== 12'hf00) begin
      n_fail++;
      $display("FAIL pal_reset_default got=%h exp=f00", rgb);
    end
    bus.pix_en  = 1'b0;
    bus.pal_we  = 1'b1;
    bus.pal_idx = 4'h3;
    bus.pal_rgb = 12'h123;
    step();
    bus.pal_we = 1'b0;
    run_to(35);
    rgb = {bus.red, bus.green, bus.blue};
    n_checks++;
    if (rgb !== 12'h123) begin
      n_fail++;
      $display("FAIL pal_write_pix_en_low got=%h exp=123", rgb);
    end
  endtask

  task automatic test_pix_en_throttle();
    logic [31:0] got, exp;
    do_reset();
    while (cyc < FRAME + 12) begin
      bus.pix_en = 1'b1;
      step();
      got = obs_vec();
      exp = exp_vec(cyc);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL throttle_enabled n=%0d got=%h exp=%h", cyc, got, exp);
      end
      bus.pix_en = 1'b0;
      step();
      got = obs_vec();
      exp = exp_vec(cyc) & ~32'h1;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL throttle_held n=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
    bus.pix_en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] got;
    int first_fs, second_fs;
    do_reset();
    run_to(10 * HT + 7);
    reset = 1'b1;
    step();
    got = obs_vec();
    n_checks++;
    if (got !== {16'h0200, 12'h000, 4'b1100}) begin
      n_fail++;
      $display("FAIL midframe_reset got=%h exp=%h", got, {16'h0200, 12'h000, 4'b1100});
    end
    reset    = 1'b0;
    cyc      = 0;
    first_fs  = -1;
    second_fs = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      if (bus.frame_start) begin
        if (first_fs < 0)       first_fs  = cyc;
        else if (second_fs < 0) second_fs = cyc;
      end
    end
    n_checks++;
    if (first_fs !== L) begin
      n_fail++;
      $display("FAIL first_frame_start got=%0d exp=%0d", first_fs, L);
    end
    n_checks++;
    if (second_fs !== L + FRAME) begin
      n_fail++;
      $display("FAIL next_frame_start got=%0d exp=%0d", second_fs, L + FRAME);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    bus.pix_en  = 1'b0;
    bus.pal_we  = 1'b0;
    bus.pal_idx = 4'h0;
    bus.pal_rgb = 12'h000;
    test_reset();
    test_frame_scan();
    test_address_walk();
    test_latency_colour();
    test_palette();
    test_pix_en_throttle();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
